// File: rtl/mem_loader.sv
// mem_loader: accepts a stream of DEPTH words over a valid/ready handshake and
// writes them to consecutive memory addresses 0..DEPTH-1. It keeps a word
// count and a running checksum, and pulses done once the last word is written.
//
// Handshake: a word transfers on a rising edge where in_valid=1 and
// in_ready=1. in_ready is registered and is high only while loading, so the
// source may hold in_valid high at any time without effect outside a load.
module mem_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     go,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     W_en,
  output logic [ADDR_W-1:0]        W_addr,
  output logic [DATA_W-1:0]        W_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          count,
  output logic [DATA_W+ADDR_W-1:0] checksum,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Count value at which the next accepted word is the last one (DEPTH-1).
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t                     state, state_n;
  logic                       in_ready_n;
  logic                       w_en_n;
  logic [ADDR_W-1:0]          w_addr_n;
  logic [DATA_W-1:0]          w_data_n;
  logic                       busy_n;
  logic                       done_n;
  logic [ADDR_W:0]            count_n;
  logic [DATA_W+ADDR_W-1:0]   checksum_n;
  logic                       handshake;

  assign handshake = in_valid & in_ready;
  assign dbg_state = state;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n    = state;
    in_ready_n = 1'b0;
    w_en_n     = 1'b0;
    w_addr_n   = W_addr;
    w_data_n   = W_data;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    count_n    = count;
    checksum_n = checksum;
    case (state)
      IDLE: begin
        if (go) begin
          state_n    = LOAD;
          in_ready_n = 1'b1;
          busy_n     = 1'b1;
          count_n    = '0;
          checksum_n = '0;
        end
      end
      LOAD: begin
        busy_n     = 1'b1;
        in_ready_n = 1'b1;
        if (handshake) begin
          w_en_n     = 1'b1;
          w_addr_n   = count[ADDR_W-1:0];
          w_data_n   = in_data;
          count_n    = count + 1'b1;
          checksum_n = checksum + {{ADDR_W{1'b0}}, in_data};
          // Drop in_ready on the same edge as the final word so word
          // DEPTH+1 can never be accepted.
          if (count == LAST) begin
            state_n    = FLUSH;
            in_ready_n = 1'b0;
          end
        end
      end
      FLUSH: begin
        // Final write is on the outputs during this cycle.
        state_n = DONE;
        done_n  = 1'b1;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      W_en     <= 1'b0;
      W_addr   <= '0;
      W_data   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      checksum <= '0;
    end else begin
      state    <= state_n;
      in_ready <= in_ready_n;
      W_en     <= w_en_n;
      W_addr   <= w_addr_n;
      W_data   <= w_data_n;
      busy     <= busy_n;
      done     <= done_n;
      count    <= count_n;
      checksum <= checksum_n;
    end
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter DATA_W, default 8, width of each data word.
REQ-002 Parameter ADDR_W, default 8, memory address width; DEPTH = 2**ADDR_W (256 at default).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 go  input  1  start request; sampled only in IDLE.
REQ-006 in_valid  input  1  source presents a word on in_data.
REQ-007 in_data  input  DATA_W  incoming word.
REQ-008 in_ready  output  1  loader accepts a word this cycle.
REQ-009 W_en  output  1  memory write strobe, one cycle per word.
REQ-010 W_addr  output  ADDR_W  memory write address.
REQ-011 W_data  output  DATA_W  memory write data.
REQ-012 busy  output  1  high while in LOAD or FLUSH state.
REQ-013 done  output  1  one-cycle pulse when all DEPTH words have been written.
REQ-014 count  output  ADDR_W+1  number of words accepted in the current or last load.
REQ-015 checksum  output  DATA_W+ADDR_W  unsigned sum of all words accepted in the current or last load.

Function
REQ-016 FSM states: IDLE, LOAD, FLUSH, DONE; all outputs registered.
REQ-017 IDLE: in_ready=0, busy=0; if go=1, next state LOAD, count and checksum cleared to 0 on the same edge.
REQ-018 LOAD: in_ready=1, busy=1; a handshake is in_valid=1 AND in_ready=1 on a rising edge.
REQ-019 On each handshake, next cycle: W_en=1, W_addr=count (old value), W_data=in_data; count increments by 1; checksum adds zero-extended in_data.
REQ-020 Without a handshake, W_en is 0 the next cycle; W_addr and W_data hold their values.
REQ-021 Back-to-back handshakes are sustained at one word per cycle with no bubbles.
REQ-022 The handshake that brings count to DEPTH moves the FSM to FLUSH; in_ready drops to 0 that same edge, so no word DEPTH+1 is ever accepted.
REQ-023 FLUSH: one cycle, during which the final W_en=1 (W_addr=DEPTH-1) is presented; next state DONE.
REQ-024 DONE: done=1 for exactly one cycle, busy=0, in_ready=0; next state IDLE.
REQ-025 go is ignored in LOAD, FLUSH and DONE; in_valid is ignored outside LOAD.
REQ-026 count and checksum hold their final values after DONE until the next accepted go.
REQ-027 checksum wraps modulo 2**(DATA_W+ADDR_W); this cannot occur at the default parameters (max 255*256 < 2**16).
REQ-028 The write address sequence is strictly 0,1,...,DEPTH-1, with no skips or repeats.

Reset
REQ-029 Rst=1 forces, asynchronously: state=IDLE, in_ready=0, W_en=0, W_addr=0, W_data=0, busy=0, done=0, count=0, checksum=0.
REQ-030 Rst asserted mid-LOAD aborts the load; no W_en is issued after Rst rises, and a new go is required to restart.
REQ-031 The first edge after Rst deasserts behaves as IDLE.

Verification
REQ-032 Full load: go pulse, then 256 consecutive words 0..255 with in_valid held high -> W_en high 256 consecutive cycles, addr 0..255, data=addr; done pulses one cycle after the last write; count=256; checksum=32640.
REQ-033 Stalled source: in_valid toggles 1,0,1,0 over 512 cycles with data=8'hFF -> exactly 256 writes, W_en never high in a cycle following an in_valid=0 cycle, checksum=65280, single done pulse.
REQ-034 Overrun: in_valid held high for 300 cycles after go -> in_ready low from the cycle after the 256th handshake; exactly 256 writes.
REQ-035 Spurious inputs: go=1 during LOAD and in_valid=1 while IDLE -> no restart, no write, count unchanged.
REQ-036 Abort: Rst asserted after 100 words, between clock edges -> all outputs zero immediately; a subsequent go and full load produces addresses starting at 0 and count=256.
REQ-037 Reload: two full loads back-to-back, with go asserted in the cycle after done -> the second load clears count and checksum, and the results match the second data set only.
